pipelined_barrel_shifter: RTL

//   Parametrised, pipelined successor to the 32-bit combinational shifter. Performs logical/arithmetic

---
 rtl/pipelined_barrel_shifter_pkg.sv | 15 +
 rtl/pipelined_barrel_shifter_shift_level.sv | 36 +++
 rtl/pipelined_barrel_shifter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
package barrel_shifter_pkg;

  typedef struct packed {
    logic shift_left;
    logic is_signed;
    logic rotate;
  } stage_ctrl_t;

  // Levels per stage: ceiling split so the final stage absorbs the remainder.
  function automatic int levels_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// One combinational 2**LEVEL step of the barrel shifter, covering every shift/rotate mode.
module shift_level
  import barrel_shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEVEL  = 0
) (
  input  stage_ctrl_t       i_ctrl,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int DIST = 1 << LEVEL;

  // Arithmetic fill reuses the current MSB, which still holds the operand sign after earlier levels.
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      if (i_ctrl.rotate) begin
        if (i_ctrl.shift_left) begin
          o_data = {i_data[DATA_W-1-DIST:0], i_data[DATA_W-1:DATA_W-DIST]};
        end else begin
          o_data = {i_data[DIST-1:0], i_data[DATA_W-1:DIST]};
        end
      end else if (i_ctrl.shift_left) begin
        o_data = i_data << DIST;
      end else if (i_ctrl.is_signed) begin
        o_data = $signed(i_data) >>> DIST;
      end else begin
        o_data = i_data >> DIST;
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shift/rotate unit with valid/ready handshake, global stall and a pass-through tag.
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_shift_left,
  input  logic               i_signed,
  input  logic               i_rotate,
  input  logic [SHAMT_W-1:0] i_shift_amt,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic [TAG_W-1:0]   o_tag
);

  localparam int LPS = levels_per_stage(SHAMT_W, STAGES);

  // Index s of the *_p arrays is the input side of stage s; index STAGES is the output.
  logic               adv;
  logic               valid_p   [STAGES+1];
  logic [TAG_W-1:0]   tag_p     [STAGES+1];
  logic [DATA_W-1:0]  data_p    [STAGES+1];
  stage_ctrl_t        ctrl_p    [STAGES];
  logic [SHAMT_W-1:0] amt_p     [STAGES];
  logic [DATA_W-1:0]  stage_res [STAGES];
  logic [DATA_W-1:0]  lvl_in    [SHAMT_W];
  logic [DATA_W-1:0]  lvl_out   [SHAMT_W];

  assign adv      = ~valid_p[STAGES] | i_ready;
  assign o_ready  = adv;
  assign o_valid  = valid_p[STAGES];
  assign o_data   = data_p[STAGES];
  assign o_tag    = tag_p[STAGES];

  // Rotate takes precedence, so the signed flag is dropped for rotates right at the entry.
  assign valid_p[0] = i_valid & adv;
  assign tag_p[0]   = i_tag;
  assign data_p[0]  = i_data;
  assign amt_p[0]   = i_shift_amt;
  assign ctrl_p[0]  = '{shift_left: i_shift_left,
                        is_signed:  i_signed & ~i_rotate,
                        rotate:     i_rotate};

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int ST = k / LPS;

    if (k % LPS == 0) begin : g_first
      assign lvl_in[k] = data_p[ST];
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end

    shift_level #(
      .DATA_W (DATA_W),
      .LEVEL  (k)
    ) u_level (
      .i_ctrl (ctrl_p[ST]),
      .i_en   (amt_p[ST][k]),
      .i_data (lvl_in[k]),
      .o_data (lvl_out[k])
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * LPS;
    localparam int LAST  = (((s + 1) * LPS < SHAMT_W) ? (s + 1) * LPS : SHAMT_W) - 1;

    // A stage left with no levels by the ceiling split is a plain register slice.
    if (FIRST < SHAMT_W) begin : g_work
      assign stage_res[s] = lvl_out[LAST];
    end else begin : g_pass
      assign stage_res[s] = data_p[s];
    end

    logic              valid_d, valid_q;
    logic [TAG_W-1:0]  tag_d, tag_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (adv) begin
        valid_d = valid_p[s];
        tag_d   = tag_p[s];
        data_d  = stage_res[s];
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
      end
    end

    assign valid_p[s+1] = valid_q;
    assign tag_p[s+1]   = tag_q;
    assign data_p[s+1]  = data_q;

    // Mode and distance travel only as far as a later stage still needs them.
    if (s < STAGES - 1) begin : g_fwd
      stage_ctrl_t        ctrl_d, ctrl_q;
      logic [SHAMT_W-1:0] amt_d, amt_q;

      always_comb begin
        ctrl_d = ctrl_q;
        amt_d  = amt_q;
        if (adv) begin
          ctrl_d = ctrl_p[s];
          amt_d  = amt_p[s];
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          ctrl_q <= '0;
          amt_q  <= '0;
        end else begin
          ctrl_q <= ctrl_d;
          amt_q  <= amt_d;
        end
      end

      assign ctrl_p[s+1] = ctrl_q;
      assign amt_p[s+1]  = amt_q;
    end
  end

endmodule
